// File: rtl/infrared_rcv.sv
// NEC infrared receiver: synchronizes the IR pin, measures pulse widths and decodes checked frames.
// Optional repeat-code support is built when IR_REPEAT_EN is defined.
module infrared_rcv #(
    parameter int unsigned CLK_FREQ_MHZ = 50,
    parameter int unsigned TIMEOUT_US   = 12000,
    // Divides every timing window; 1 for real hardware, larger to shorten simulation.
    parameter int unsigned TIME_DIV     = 1
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        infrared_in,
    output logic [19:0] data,
    output logic        frame_vld,
    output logic        repeat_en
);

    localparam logic [19:0] LeadLowMin  = 20'(8000 * CLK_FREQ_MHZ / TIME_DIV);
    localparam logic [19:0] LeadLowMax  = 20'(10000 * CLK_FREQ_MHZ / TIME_DIV);
    localparam logic [19:0] LeadHighMin = 20'(4000 * CLK_FREQ_MHZ / TIME_DIV);
    localparam logic [19:0] LeadHighMax = 20'(5000 * CLK_FREQ_MHZ / TIME_DIV);
    localparam logic [19:0] ShortMin    = 20'(400 * CLK_FREQ_MHZ / TIME_DIV);
    localparam logic [19:0] ShortMax    = 20'(700 * CLK_FREQ_MHZ / TIME_DIV);
    localparam logic [19:0] LongMin     = 20'(1400 * CLK_FREQ_MHZ / TIME_DIV);
    localparam logic [19:0] LongMax     = 20'(1900 * CLK_FREQ_MHZ / TIME_DIV);
    localparam logic [19:0] Timeout     = 20'(TIMEOUT_US * CLK_FREQ_MHZ / TIME_DIV);

    typedef enum logic [2:0] {StIdle, StLeadLow, StLeadHigh, StBitLow, StBitHigh} state_e;

    state_e      r_state, w_state_d;
    logic [2:0]  r_sync;
    logic [19:0] r_cnt;
    logic [31:0] r_shift;
    logic [4:0]  r_bitcnt;
    logic        r_done;
    logic [19:0] r_data;
    logic        r_frame_vld;
    logic        w_fall, w_rise, w_clr, w_shift, w_bit, w_last, w_frame_ok;

    function automatic logic in_win(input logic [19:0] v, input logic [19:0] lo,
                                    input logic [19:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

    assign w_fall     = r_sync[2] & ~r_sync[1];
    assign w_rise     = ~r_sync[2] & r_sync[1];
    assign w_frame_ok = (r_shift[7:0] == ~r_shift[15:8]) && (r_shift[23:16] == ~r_shift[31:24]);

`ifdef IR_REPEAT_EN
    localparam logic [19:0] RepeatMin = 20'(2000 * CLK_FREQ_MHZ / TIME_DIV);
    localparam logic [19:0] RepeatMax = 20'(2500 * CLK_FREQ_MHZ / TIME_DIV);
    logic w_rep, r_rep_pend, r_got_frame, r_repeat_en;
`endif

    always_comb begin
        w_state_d = r_state;
        w_clr     = 1'b0;
        w_shift   = 1'b0;
        w_bit     = 1'b0;
        w_last    = 1'b0;
`ifdef IR_REPEAT_EN
        w_rep     = 1'b0;
`endif
        if (r_state != StIdle && r_cnt >= Timeout) begin
            w_state_d = StIdle;
        end else begin
            unique case (r_state)
                StIdle: if (w_fall) w_state_d = StLeadLow;
                StLeadLow: if (w_rise) begin
                    w_state_d = in_win(r_cnt, LeadLowMin, LeadLowMax) ? StLeadHigh : StIdle;
                end
                StLeadHigh: if (w_fall) begin
                    w_state_d = StIdle;
                    if (in_win(r_cnt, LeadHighMin, LeadHighMax)) begin
                        w_clr     = 1'b1;
                        w_state_d = StBitLow;
                    end
`ifdef IR_REPEAT_EN
                    else if (in_win(r_cnt, RepeatMin, RepeatMax)) begin
                        w_rep = 1'b1;
                    end
`endif
                end
                StBitLow: if (w_rise) begin
                    w_state_d = in_win(r_cnt, ShortMin, ShortMax) ? StBitHigh : StIdle;
                end
                StBitHigh: if (w_fall) begin
                    w_state_d = StIdle;
                    if (in_win(r_cnt, ShortMin, ShortMax) || in_win(r_cnt, LongMin, LongMax)) begin
                        w_shift = 1'b1;
                        w_bit   = in_win(r_cnt, LongMin, LongMax);
                        if (r_bitcnt == 5'd31) w_last = 1'b1;
                        else                   w_state_d = StBitLow;
                    end
                end
                default: w_state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_sync      <= 3'b111;
            r_cnt       <= '0;
            r_state     <= StIdle;
            r_shift     <= '0;
            r_bitcnt    <= '0;
            r_done      <= 1'b0;
            r_data      <= '0;
            r_frame_vld <= 1'b0;
        end else begin
            r_sync  <= {r_sync[1:0], infrared_in};
            r_state <= w_state_d;
            if (w_fall || w_rise)  r_cnt <= '0;
            else if (r_cnt != '1) r_cnt <= r_cnt + 20'd1;
            // Right shift: the first received bit ends up in bit 0 after 32 bits.
            if (w_clr) begin
                r_shift  <= '0;
                r_bitcnt <= '0;
            end else if (w_shift) begin
                r_shift  <= {w_bit, r_shift[31:1]};
                r_bitcnt <= r_bitcnt + 5'd1;
            end
            r_done      <= w_last;
            r_frame_vld <= r_done & w_frame_ok;
            if (r_done && w_frame_ok) r_data <= {12'b0, r_shift[23:16]};
        end
    end

`ifdef IR_REPEAT_EN
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_rep_pend  <= 1'b0;
            r_got_frame <= 1'b0;
            r_repeat_en <= 1'b0;
        end else begin
            r_rep_pend  <= w_rep;
            r_repeat_en <= r_rep_pend & r_got_frame;
            if (r_done && w_frame_ok) r_got_frame <= 1'b1;
        end
    end
    assign repeat_en = r_repeat_en;
`else
    assign repeat_en = 1'b0;
`endif

    assign data      = r_data;
    assign frame_vld = r_frame_vld;

endmodule

// File: tb/tb_infrared_rcv.sv
// Scoreboard bench for infrared_rcv: directed NEC waveforms, monitor pops expected pulses.
// Runs with scaled timing (1 MHz, windows divided by 20) to keep frames short.
module tb_infrared_rcv;

    localparam int T_LL     = 450;  // 9000 us leader low
    localparam int T_LL_BAD = 350;  // 7000 us, out of window
    localparam int T_LH     = 225;  // 4500 us leader high
    localparam int T_RH     = 112;  // 2250 us repeat high
    localparam int T_BL     = 28;   // 560 us bit low
    localparam int T_B0     = 28;
    localparam int T_B1     = 84;   // 1690 us
    localparam int T_GAP_TO = 650;  // 13000 us, past the 12000 us timeout

    typedef struct {
        bit          rep;
        logic [19:0] val;
    } exp_t;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        infrared_in;
    logic [19:0] data;
    logic        frame_vld;
    logic        repeat_en;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   last_fall_cyc = 0;
    exp_t q[$];
    logic [19:0] mon_data = '0;
    logic        prev_pulse = 1'b0;

    infrared_rcv #(
        .CLK_FREQ_MHZ(1),
        .TIMEOUT_US  (12000),
        .TIME_DIV    (20)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .infrared_in(infrared_in),
        .data       (data),
        .frame_vld  (frame_vld),
        .repeat_en  (repeat_en)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at cycle %0d", name, got, exp, cyc);
        end
    endtask

    task automatic drive(input logic lvl, input int n);
        @(negedge sys_clk);
        if (infrared_in && !lvl) last_fall_cyc = cyc;
        infrared_in = lvl;
        repeat (n - 1) @(negedge sys_clk);
    endtask

    task automatic push(input bit rep, input logic [19:0] val);
        exp_t e;
        e.rep = rep;
        e.val = val;
        q.push_back(e);
    endtask

    // Sends nbits of w LSB first; a full frame ends with the stop burst, a short one with a long idle.
    task automatic send_frame(input logic [31:0] w, input int nbits, input int ll);
        drive(1'b0, ll);
        drive(1'b1, T_LH);
        for (int i = 0; i < nbits; i++) begin
            drive(1'b0, T_BL);
            drive(1'b1, w[i] ? T_B1 : T_B0);
        end
        if (nbits == 32) begin
            drive(1'b0, T_BL);
            drive(1'b1, 200);
        end else begin
            drive(1'b1, T_GAP_TO);
        end
    endtask

    task automatic send_repeat();
        drive(1'b0, T_LL);
        drive(1'b1, T_RH);
        drive(1'b0, T_BL);
        drive(1'b1, 200);
    endtask

    always @(negedge sys_clk) begin
        exp_t e;
        if (!sys_rst_n) mon_data = '0;
        if (frame_vld || repeat_en) begin
            chk("pulse_exclusive", {31'b0, frame_vld & repeat_en}, 32'd0);
            chk("pulse_single_cycle", {31'b0, prev_pulse}, 32'd0);
            if (q.size() == 0) begin
                chk("unexpected_pulse", {30'b0, frame_vld, repeat_en}, 32'd0);
            end else begin
                e = q.pop_front();
                chk("pulse_kind", {31'b0, repeat_en}, {31'b0, e.rep});
                chk("pulse_latency", cyc - last_fall_cyc, 32'd4);
                if (!e.rep) mon_data = e.val;
                chk("pulse_data", {12'b0, data}, {12'b0, e.val});
            end
        end
        chk("data_stable", {12'b0, data}, {12'b0, mon_data});
        prev_pulse = frame_vld | repeat_en;
    end

    initial begin
        #(10 * 90000);
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        infrared_in = 1'b1;
        sys_rst_n   = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        chk("reset_data", {12'b0, data}, 32'd0);
        chk("reset_frame_vld", {31'b0, frame_vld}, 32'd0);
        chk("reset_repeat_en", {31'b0, repeat_en}, 32'd0);
        @(posedge sys_clk);
        #2 sys_rst_n = 1'b1;
        drive(1'b1, 20);

        // Repeat before any frame: never a pulse.
        send_repeat();

        push(1'b0, 20'h00045);
        send_frame(32'hBA45FF00, 32, T_LL);
`ifdef IR_REPEAT_EN
        push(1'b1, 20'h00045);
`endif
        send_repeat();

        // cmd_n 0xBB fails the check.
        send_frame(32'hBB45FF00, 32, T_LL);
        chk("bad_check_hold", {12'b0, data}, 32'h45);

        send_frame(32'hE916FF00, 32, T_LL_BAD);
        chk("bad_leader_hold", {12'b0, data}, 32'h45);
        push(1'b0, 20'h00016);
        send_frame(32'hE916FF00, 32, T_LL);

        // 17 bits then a 13 ms idle high: timeout.
        send_frame(32'hF708FF00, 17, T_LL);
        chk("timeout_hold", {12'b0, data}, 32'h16);
        push(1'b0, 20'h00008);
        send_frame(32'hF708FF00, 32, T_LL);

        // Reset during bit 10.
        drive(1'b0, T_LL);
        drive(1'b1, T_LH);
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, T_BL);
            drive(1'b1, (i % 2 == 1) ? T_B1 : T_B0);
        end
        drive(1'b0, 10);
        @(posedge sys_clk);
        #2;
        sys_rst_n   = 1'b0;
        infrared_in = 1'b1;
        #1;
        chk("midreset_data", {12'b0, data}, 32'd0);
        chk("midreset_frame_vld", {31'b0, frame_vld}, 32'd0);
        repeat (3) @(posedge sys_clk);
        #2 sys_rst_n = 1'b1;
        drive(1'b1, 50);
        push(1'b0, 20'h0005A);
        send_frame(32'hA55AEF10, 32, T_LL);

        chk("scoreboard_empty", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/infrared_rcv.md
# infrared_rcv

NEC-protocol infrared receiver front end. Samples the demodulated IR receiver pin, measures pulse widths, decodes 32-bit NEC frames and checks them. Presents the validated command byte as a 20-bit binary value. Sits directly upstream of the binary-to-BCD converter, whose `data` input it drives; that converter then feeds the 7-segment display.

## Interface
Parameters:
- `CLK_FREQ_MHZ`, 50, system clock frequency in MHz; every timing window below is in µs and is multiplied by this value to get cycle counts.
- `TIMEOUT_US`, 12000, maximum time without an input edge before any non-IDLE state aborts.

Ports:
- `sys_clk` input 1: system clock.
- `sys_rst_n` input 1: asynchronous, active-low reset.
- `infrared_in` input 1: demodulated IR pin; idle high, carrier bursts read as low; asynchronous to `sys_clk`.
- `data` output 20: `{12'b0, command[7:0]}` of the last valid frame.
- `frame_vld` output 1: one-cycle pulse when `data` is loaded from a new valid frame.
- `repeat_en` output 1: one-cycle pulse on a valid NEC repeat code.

## Operation
- `infrared_in` passes through a 2-FF synchronizer and a third register. Falling and rising edges are detected from the last two stages.
- A 20-bit counter `cnt` is cleared on every detected edge and otherwise increments, saturating at its maximum. All widths are measured as `cnt` at the edge that ends a phase.
- States: IDLE, LEAD_LOW, LEAD_HIGH, BIT_LOW, BIT_HIGH.
- IDLE: on a falling edge, go to LEAD_LOW. Rising edges are ignored.
- LEAD_LOW: on a rising edge, go to LEAD_HIGH if the width is 8000–10000 µs; otherwise go to IDLE.
- LEAD_HIGH: on a falling edge:
  - width 4000–5000 µs: clear the bit counter and the shift register, go to BIT_LOW.
  - width 2000–2500 µs: repeat code; see Configuration. Go to IDLE.
  - anything else: go to IDLE.
- BIT_LOW: on a rising edge, go to BIT_HIGH if the width is 400–700 µs; otherwise go to IDLE.
- BIT_HIGH: on a falling edge, classify the width:
  - 400–700 µs: bit = 0.
  - 1400–1900 µs: bit = 1.
  - anything else: go to IDLE and discard the frame.
  - Each bit is shifted into a 32-bit register LSB first (first received bit becomes bit 0).
  - Increment the bit counter. If it has not reached 32, go to BIT_LOW.
- Frame complete (32nd bit): go to IDLE. Byte order is addr = [7:0], addr_n = [15:8], cmd = [23:16], cmd_n = [31:24].
  - Valid only if addr == ~addr_n and cmd == ~cmd_n.
  - Valid: load `data <= {12'b0, cmd}`, pulse `frame_vld`, set an internal `got_frame` flag.
  - Invalid: `data` unchanged, no pulse.
- The NEC stop burst after bit 32 enters LEAD_LOW and fails the leader-width check. No output is affected.
- Timeout: in any non-IDLE state, if `cnt` reaches `TIMEOUT_US*CLK_FREQ_MHZ`, go to IDLE and discard the partial frame.
- Window boundaries are inclusive at both ends.

## Timing
- Reset values: state IDLE, `cnt` 0, synchronizer registers 1, shift register 0, `got_frame` 0, `data` 0, `frame_vld` 0, `repeat_en` 0.
- Edge detection occurs 3 `sys_clk` cycles after the first clock edge that samples a pin transition.
- `data`, `frame_vld` and `repeat_en` update on the clock edge following the detection cycle, i.e. a total latency of 4 cycles from the first sampling of the final falling edge.
- Pulse widths are measured to ±1 cycle of synchronizer jitter.
- `frame_vld` and `repeat_en` are never high in the same cycle and never high for two consecutive cycles.
- `data` is stable between `frame_vld` pulses.
- Reset asserted mid-frame: everything returns to reset values immediately. After release, decoding restarts only on a new leader.
- Counter saturation in IDLE is harmless; IDLE has no timeout.

## Configuration
- `IR_REPEAT_EN` defined:
  - A valid repeat code (LEAD_HIGH width 2000–2500 µs) pulses `repeat_en` only if `got_frame` = 1.
  - `data` is unchanged.
- `IR_REPEAT_EN` undefined:
  - The repeat-code branch is not built. A 2000–2500 µs leader-high is handled as "anything else" (go to IDLE).
  - `repeat_en` is tied to 0 and `got_frame` is omitted.

## Test plan
- Valid frame addr 0x00, cmd 0x45 (bytes 00 FF 45 BA) at 50 MHz -> `data` = 0x00045 and a single `frame_vld` pulse 4 cycles after the last data falling edge.
- Same frame with cmd_n = 0xBB (check fails) -> no `frame_vld`, `data` keeps its previous value.
- Leader low of 7000 µs, then a full frame body -> no output; the next correct frame with cmd 0x16 -> `data` = 0x00016.
- Frame cut after bit 17 with the line held high for 13 ms -> return to IDLE, no output; the next valid frame decodes correctly.
- With `IR_REPEAT_EN`: repeat code before any frame -> no pulse. Valid frame then repeat code -> one `repeat_en` pulse, `data` unchanged. Without the macro, `repeat_en` stays 0.
- `sys_rst_n` low for 3 cycles during bit 10 -> outputs 0 immediately; the following complete frame decodes normally.
